// File: rtl/tpu_pkg.sv
// Shared TPU datapath types, default map geometry and compare helper.
// Used by the conv, dense and max-pool stages.
package tpu_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 24;
    localparam int DEF_IMG_H = 24;
    localparam int DEF_POOL  = 2;
    localparam int MAX_W     = 32;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [MAX_W-1:0] word_t;

    // Max of two w-bit values held zero-extended in a word; ties keep a.
    // Signed mode flips the sign bit so one unsigned compare serves both.
    function automatic word_t max_sel(
        input word_t a,
        input word_t b,
        input bit    sgn,
        input int    w
    );
        word_t ka;
        word_t kb;
        ka = a;
        kb = b;
        if (sgn) begin
            ka[w-1] = ~ka[w-1];
            kb[w-1] = ~kb[w-1];
        end
        return (kb > ka) ? b : a;
    endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Row of partial vertical maxima, one entry per pooling window column.
// Synchronous write, combinational read.
module maxpool_linebuf #(
    parameter int DEPTH  = 12,
    parameter int DATA_W = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the partial maximum for one window column
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max-pool over a raster pixel stream.
// Optional fused ReLU on the output when MAXPOOL_RELU_EN is defined.
module maxpool_stream
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int POOL   = DEF_POOL,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int NWIN = IMG_W / POOL;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    function automatic logic [DATA_W-1:0] mx(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return DATA_W'(max_sel(word_t'(a), word_t'(b), SIGNED != 0, DATA_W));
    endfunction

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [PW-1:0]     cp;
    logic [PW-1:0]     rp;
    logic [KW-1:0]     k;
    logic [DATA_W-1:0] h_acc;
    logic [DATA_W-1:0] h_new;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] v_out;
    logic              acc;
    logic              col_end;
    logic              row_end;
    logic              lb_we;
    logic              load;
    logic              frame_end;

    assign in_ready  = !out_valid || out_ready;
    assign acc       = in_valid && in_ready;
    assign col_end   = (cp == PW'(POOL - 1));
    assign row_end   = (rp == PW'(POOL - 1));
    assign h_new     = (cp == '0) ? in_data : mx(h_acc, in_data);
    assign v         = (rp == '0) ? h_new : mx(lb_rd, h_new);
    assign lb_we     = acc && col_end && !row_end;
    assign load      = acc && col_end && row_end;
    assign frame_end = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

`ifdef MAXPOOL_RELU_EN
    assign v_out = ((SIGNED != 0) && v[DATA_W-1]) ? '0 : v;
`else
    assign v_out = v;
`endif

    maxpool_linebuf #(
        .DEPTH  (NWIN),
        .DATA_W (DATA_W)
    ) u_lbuf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_idx  (k),
        .wr_data (v),
        .rd_idx  (k),
        .rd_data (lb_rd)
    );

    // Raster position counters and the running horizontal maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            cp    <= '0;
            rp    <= '0;
            k     <= '0;
            h_acc <= '0;
        end else if (acc) begin
            h_acc <= h_new;
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                cp  <= '0;
                k   <= '0;
                rp  <= row_end ? '0 : rp + 1'b1;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
                if (col_end) begin
                    cp <= '0;
                    k  <= k + 1'b1;
                end else begin
                    cp <= cp + 1'b1;
                end
            end
        end
    end

    // Single output register; held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= v_out;
            out_valid <= 1'b1;
            out_last  <= frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: 24x24 signed/unsigned and 6x6 POOL=3.
// Expected outputs come from a window-max reference model over the frame data.
module tb_maxpool_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dat_a;
    logic       vld_a;
    logic       ordy_a;
    logic [7:0] dat_b;
    logic       vld_b;
    logic       ordy_b;

    logic       rdy_s, ov_s, ol_s;
    logic [7:0] od_s;
    logic       rdy_u, ov_u, ol_u;
    logic [7:0] od_u;
    logic       rdy_p, ov_p, ol_p;
    logic [7:0] od_p;

    maxpool_stream #(.DATA_W(8), .IMG_W(24), .IMG_H(24), .POOL(2), .SIGNED(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_data(dat_a), .in_valid(vld_a),
        .in_ready(rdy_s), .out_data(od_s), .out_valid(ov_s),
        .out_ready(ordy_a), .out_last(ol_s));

    maxpool_stream #(.DATA_W(8), .IMG_W(24), .IMG_H(24), .POOL(2), .SIGNED(0)) u_u (
        .clk(clk), .rst_n(rst_n), .in_data(dat_a), .in_valid(vld_a),
        .in_ready(rdy_u), .out_data(od_u), .out_valid(ov_u),
        .out_ready(ordy_a), .out_last(ol_u));

    maxpool_stream #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .POOL(3), .SIGNED(1)) u_p (
        .clk(clk), .rst_n(rst_n), .in_data(dat_b), .in_valid(vld_b),
        .in_ready(rdy_p), .out_data(od_p), .out_valid(ov_p),
        .out_ready(ordy_b), .out_last(ol_p));

    int nvec = 0;
    int nfail = 0;

    logic [8:0] expq [0:2][$];
    logic [7:0] st [0:1][$];
    bit         hold [0:2];
    logic [7:0] hd [0:2];
    logic       hl [0:2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: max over each complete window among the first n pixels
    task automatic model(input int id, input int sid, input int w, input int h,
                         input int p, input bit sgn, input int base, input int n);
        int best;
        int val;
        int lastpix;
        logic lb;
        for (int by = 0; by < h / p; by++) begin
            for (int bx = 0; bx < w / p; bx++) begin
                lastpix = (by * p + p - 1) * w + bx * p + p - 1;
                if (lastpix < n) begin
                    best = -100000;
                    for (int dy = 0; dy < p; dy++) begin
                        for (int dx = 0; dx < p; dx++) begin
                            val = sgn
                                ? int'($signed(st[sid][base + (by * p + dy) * w + bx * p + dx]))
                                : int'(st[sid][base + (by * p + dy) * w + bx * p + dx]);
                            if (val > best) best = val;
                        end
                    end
`ifdef MAXPOOL_RELU_EN
                    if (sgn && best < 0) best = 0;
`endif
                    lb = (by == h / p - 1) && (bx == w / p - 1);
                    expq[id].push_back({lb, 8'(best)});
                end
            end
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic [7:0] od,
                       input logic ol, input logic ordy, input logic irdy);
        logic [8:0] e;
        check($sformatf("in_ready_eq%0d", id), 32'(irdy), 32'(!ov || ordy));
        if (hold[id]) begin
            check($sformatf("hold_valid%0d", id), 32'(ov), 32'(1));
            check($sformatf("hold_data%0d", id), 32'(od), 32'(hd[id]));
            check($sformatf("hold_last%0d", id), 32'(ol), 32'(hl[id]));
        end
        if (ov && ordy) begin
            if (expq[id].size() == 0) begin
                check($sformatf("spurious%0d", id), 32'(ov), 32'(0));
            end else begin
                e = expq[id].pop_front();
                check($sformatf("data%0d", id), 32'(od), 32'(e[7:0]));
                check($sformatf("last%0d", id), 32'(ol), 32'(e[8]));
            end
        end
        hold[id] = ov && !ordy;
        hd[id] = od;
        hl[id] = ol;
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            mon(0, ov_s, od_s, ol_s, ordy_a, rdy_s);
            mon(1, ov_u, od_u, ol_u, ordy_a, rdy_u);
            mon(2, ov_p, od_p, ol_p, ordy_b, rdy_p);
        end else begin
            for (int i = 0; i < 3; i++) hold[i] = 1'b0;
        end
    end

    // kind 0: {55,A8/75,28}  kind 1: {80,F0/FF,81}  kind 2: random
    task automatic fill(input int kind);
        logic [7:0] px;
        st[0].delete();
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 24; c++) begin
                case (kind)
                    0: px = (r % 2 == 0) ? ((c % 2 == 0) ? 8'h55 : 8'hA8)
                                         : ((c % 2 == 0) ? 8'h75 : 8'h28);
                    1: px = (r % 2 == 0) ? ((c % 2 == 0) ? 8'h80 : 8'hF0)
                                         : ((c % 2 == 0) ? 8'hFF : 8'h81);
                    default: px = 8'($urandom);
                endcase
                st[0].push_back(px);
            end
        end
    endtask

    task automatic send(input int sid, input int n, input bit rnd);
        int idx;
        int budget;
        idx = 0;
        budget = 0;
        while (idx < n && budget < 20000) begin
            @(negedge clk);
            if (sid == 0) begin
                ordy_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                vld_a = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                dat_a = st[0][idx];
            end else begin
                ordy_b = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                vld_b = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                dat_b = st[1][idx];
            end
            #1;
            if (sid == 0 ? (vld_a && rdy_s) : (vld_b && rdy_p)) idx++;
            budget++;
        end
        check($sformatf("send%0d", sid), 32'(idx), 32'(n));
    endtask

    task automatic drain(input int sid);
        int budget;
        int left;
        budget = 0;
        do begin
            @(negedge clk);
            if (sid == 0) begin
                vld_a = 1'b0;
                ordy_a = 1'b1;
            end else begin
                vld_b = 1'b0;
                ordy_b = 1'b1;
            end
            #3;
            budget++;
            left = (sid == 0) ? expq[0].size() + expq[1].size() : expq[2].size();
        end while (left != 0 && budget < 200);
        check($sformatf("drain%0d", sid), 32'(left), 32'(0));
    endtask

    initial begin
        int pos;
        vld_a = 1'b0; ordy_a = 1'b1; dat_a = '0;
        vld_b = 1'b0; ordy_b = 1'b1; dat_b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_s", 32'(ov_s), 32'(0));
        check("rst_last_s", 32'(ol_s), 32'(0));
        check("rst_data_s", 32'(od_s), 32'(0));
        check("rst_ready_s", 32'(rdy_s), 32'(1));
        check("rst_valid_p", 32'(ov_p), 32'(0));
        check("rst_data_p", 32'(od_p), 32'(0));
        check("rst_ready_p", 32'(rdy_p), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        fill(0);
        model(0, 0, 24, 24, 2, 1'b1, 0, 576);
        model(1, 0, 24, 24, 2, 1'b0, 0, 576);
        send(0, 576, 1'b0);
        drain(0);

        fill(1);
        model(0, 0, 24, 24, 2, 1'b1, 0, 576);
        model(1, 0, 24, 24, 2, 1'b0, 0, 576);
        send(0, 576, 1'b0);
        drain(0);

        fill(2);
        model(0, 0, 24, 24, 2, 1'b1, 0, 576);
        model(1, 0, 24, 24, 2, 1'b0, 0, 576);
        send(0, 576, 1'b1);
        drain(0);

        fill(2);
        model(0, 0, 24, 24, 2, 1'b1, 0, 100);
        model(1, 0, 24, 24, 2, 1'b0, 0, 100);
        send(0, 100, 1'b1);
        @(negedge clk);
        vld_a = 1'b0;
        rst_n = 1'b0;
        expq[0].delete();
        expq[1].delete();
        #1;
        check("midrst_valid_s", 32'(ov_s), 32'(0));
        check("midrst_valid_u", 32'(ov_u), 32'(0));
        check("midrst_last_s", 32'(ol_s), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        fill(2);
        model(0, 0, 24, 24, 2, 1'b1, 0, 576);
        model(1, 0, 24, 24, 2, 1'b0, 0, 576);
        send(0, 576, 1'b1);
        drain(0);

        st[1].delete();
        for (int i = 0; i < 72; i++) st[1].push_back(8'h80);
        for (int f = 0; f < 2; f++) begin
            for (int by = 0; by < 2; by++) begin
                for (int bx = 0; bx < 2; bx++) begin
                    pos = f * 36 + (by * 3 + $urandom_range(0, 2)) * 6
                        + bx * 3 + $urandom_range(0, 2);
                    st[1][pos] = 8'h7F;
                end
            end
        end
        model(2, 1, 6, 6, 3, 1'b1, 0, 36);
        model(2, 1, 6, 6, 3, 1'b1, 36, 36);
        send(1, 72, 1'b0);
        drain(1);

        for (int i = 0; i < 72; i++) st[1][i] = 8'($urandom);
        model(2, 1, 6, 6, 3, 1'b1, 0, 36);
        model(2, 1, 6, 6, 3, 1'b1, 36, 36);
        send(1, 72, 1'b1);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
